// File: rtl/t_ff_pkg.sv
// Shared defaults and count type for the T flip-flop modulus counter.
package t_ff_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/t_ff_stage.sv
// Single T flip-flop stage: toggles when t is high, synchronous reset to 0.
module t_ff_stage (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/t_ff_mod_counter.sv
// Up/down modulus counter whose state lives in a chain of T flip-flops;
// next state is turned into a per-bit toggle mask.
module t_ff_mod_counter
  import t_ff_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t_mask;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_q;

  always_comb begin
    load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
  end

  always_comb begin
    q_d = stage_q;
    if (load) begin
      q_d = load_clamped;
    end else if (en) begin
      if (up) begin
        q_d = (stage_q == MAX_VAL) ? '0 : stage_q + WIDTH'(1);
      end else begin
        q_d = (stage_q == '0) ? MAX_VAL : stage_q - WIDTH'(1);
      end
    end
  end

  assign t_mask = stage_q ^ q_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    t_ff_stage u_stage (
      .clk (clk),
      .rst (rst),
      .t   (t_mask[gi]),
      .q   (stage_q[gi])
    );
  end

  assign tc = en & ~load & ((up & (stage_q == MAX_VAL)) | (~up & (stage_q == '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tc;
    end
  end

  assign q    = stage_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_t_ff_mod_counter.sv
// Randomized and directed bench for t_ff_mod_counter, modulus 10 and modulus 2.
module tb_t_ff_mod_counter;

  logic       clk;
  logic       rst, en, up, load;
  logic [3:0] load_val;
  logic [1:0] load_val2;
  logic [3:0] q10;
  logic [1:0] q2;
  logic       tc10, wrap10, tc2, wrap2;

  int n_tests = 0;
  int n_fail  = 0;

  int m10, mw10, m2, mw2;
  bit m_valid = 0;

  t_ff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q10), .tc(tc10), .wrap(wrap10)
  );

  t_ff_mod_counter #(.WIDTH(2), .MODULUS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val2), .q(q2), .tc(tc2), .wrap(wrap2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_val(input int cur, input int modulus, input bit r,
                                  input bit l, input int lv, input bit e, input bit u);
    if (r) return 0;
    if (l) return (lv >= modulus) ? modulus - 1 : lv;
    if (e) return u ? (cur + 1) % modulus : (cur + modulus - 1) % modulus;
    return cur;
  endfunction

  function automatic bit exp_tc(input int cur, input int modulus, input bit e,
                                input bit l, input bit u);
    return e && !l && (u ? (cur == modulus - 1) : (cur == 0));
  endfunction

  // Reference model: wrap is simply "tc was high on the last edge, no reset".
  always @(posedge clk) begin
    mw10 <= rst ? 0 : int'(exp_tc(m10, 10, en, load, up));
    mw2  <= rst ? 0 : int'(exp_tc(m2, 2, en, load, up));
    m10  <= next_val(m10, 10, rst, load, int'(load_val), en, up);
    m2   <= next_val(m2, 2, rst, load, int'(load_val2), en, up);
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("q10", int'(q10), m10);
      chk("wrap10", int'(wrap10), mw10);
      chk("tc10", int'(tc10), int'(exp_tc(m10, 10, en, load, up)));
      chk("q2", int'(q2), m2);
      chk("wrap2", int'(wrap2), mw2);
      chk("tc2", int'(tc2), int'(exp_tc(m2, 2, en, load, up)));
    end
  end

  task automatic drive(input bit r, input bit l, input int lv, input bit e, input bit u);
    rst = r; load = l; load_val = 4'(lv); en = e; up = u;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_q;
    load_val2 = 2'd0;
    drive(1, 0, 0, 0, 1);
    tick();
    chk("rst_q10", int'(q10), 0);
    chk("rst_wrap10", int'(wrap10), 0);
    chk("rst_q2", int'(q2), 0);

    // Up-count from reset through the 9->0 wrap.
    drive(0, 0, 0, 1, 1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_q = i % 10;
      chk("up_q", int'(q10), exp_q);
      chk("up_wrap", int'(wrap10), (exp_q == 0) ? 1 : 0);
      if (i <= 4) begin
        chk("mod2_q", int'(q2), i % 2);
        chk("mod2_wrap", int'(wrap2), (i % 2 == 0) ? 1 : 0);
      end
    end

    // Down-count across zero.
    load_val2 = 2'd1;
    drive(0, 1, 2, 0, 0);
    tick();
    chk("dn_load", int'(q10), 2);
    drive(0, 0, 0, 1, 0);
    tick(); chk("dn_q1", int'(q10), 1);
    tick(); chk("dn_q0", int'(q10), 0);
    chk("dn_tc_at0", int'(tc10), 1);
    tick(); chk("dn_q9", int'(q10), 9);
    chk("dn_wrap", int'(wrap10), 1);
    tick(); chk("dn_q8", int'(q10), 8);
    chk("dn_wrap_off", int'(wrap10), 0);

    // Load clamp beats enable, then the clamped value wraps.
    drive(0, 1, 5, 0, 1);
    tick(); chk("clamp_pre", int'(q10), 5);
    drive(0, 1, 13, 1, 1);
    #1 chk("clamp_tc", int'(tc10), 0);
    tick(); chk("clamp_q", int'(q10), 9);
    chk("clamp_wrap", int'(wrap10), 0);
    drive(0, 0, 0, 1, 1);
    tick(); chk("clamp_next_q", int'(q10), 0);
    chk("clamp_next_wrap", int'(wrap10), 1);

    // Hold then direction flip every edge.
    drive(0, 1, 4, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", int'(q10), 4);
      chk("hold_tc", int'(tc10), 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, (i % 2 == 0));
      tick();
      chk("dir_q", int'(q10), (i % 2 == 0) ? 5 : 4);
    end

    // Reset overrides load mid-count.
    drive(0, 1, 6, 0, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    tick(); chk("mid_q7", int'(q10), 7);
    drive(1, 1, 3, 1, 1);
    tick(); chk("mid_rst_q", int'(q10), 0);
    chk("mid_rst_wrap", int'(wrap10), 0);
    drive(0, 0, 0, 1, 1);
    tick(); chk("mid_resume1", int'(q10), 1);
    tick(); chk("mid_resume2", int'(q10), 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1);
      load_val2 = 2'($urandom_range(0, 3));
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
